// File: rtl/gpu_fill_pkg.sv
// Shared types and constants for the Tex$/CLUT$ refill sequencer.
package gpu_fill_pkg;

   localparam int unsigned TEX_BEATS  = 1;
   localparam int unsigned CLUT_BEATS = 4;
   localparam int unsigned ADR_W      = 17;

   typedef enum logic [2:0] {IDLE, ISSUE, RECV, DONE, COOL} state_t;
   typedef enum logic {SRC_TEX, SRC_CLUT} src_t;

endpackage

// File: rtl/gpu_fill_rr2.sv
// Two-requester round-robin arbiter: holds the pending flags and the last grant.
module gpu_fill_rr2
   import gpu_fill_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic texSet,
   input  logic clutSet,
   input  logic arbEn,
   output logic texPend,
   output logic clutPend,
   output logic grant,
   output src_t grantSrc
);

   src_t lastGrant;

   assign grant = arbEn && (texPend || clutPend);

   always_comb begin
      grantSrc = SRC_CLUT;
      if (texPend && clutPend)
         grantSrc = (lastGrant == SRC_TEX) ? SRC_CLUT : SRC_TEX;
      else if (texPend)
         grantSrc = SRC_TEX;
   end

   // A source is never set and granted in the same cycle: set needs pend=0, grant needs pend=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         texPend   <= 1'b0;
         clutPend  <= 1'b0;
         lastGrant <= SRC_CLUT;
      end else begin
         if (texSet)
            texPend <= 1'b1;
         if (clutSet)
            clutPend <= 1'b1;
         if (grant) begin
            lastGrant <= grantSrc;
            if (grantSrc == SRC_TEX)
               texPend <= 1'b0;
            else
               clutPend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/gpu_fill_arbiter.sv
// Refill sequencer sharing one VRAM read port between the texture and palette caches.
module gpu_fill_arbiter
   import gpu_fill_pkg::*;
(
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_tex_req,
   input  logic [ADR_W-1:0]     i_tex_adr,
   input  logic                 i_clut_req,
   input  logic [5:0]           i_clut_blk,
   input  logic [8:0]           i_clut_y,
   output logic                 o_mem_req,
   output logic [ADR_W-1:0]     o_mem_adr,
   output logic [2:0]           o_mem_len,
   input  logic                 i_mem_ack,
   input  logic                 i_mem_dvalid,
   input  logic [63:0]          i_mem_data,
   output logic                 o_tex_wr,
   output logic [ADR_W-1:0]     o_tex_wr_adr,
   output logic [63:0]          o_tex_wr_data,
   output logic                 o_tex_done,
   output logic                 o_clut_wr,
   output logic [1:0]           o_clut_wr_beat,
   output logic [5:0]           o_clut_wr_blk,
   output logic [63:0]          o_clut_wr_data,
   output logic                 o_clut_done,
   output logic                 o_pause,
   output logic                 o_busy
);

   state_t           state;
   src_t             src;
   logic [1:0]       beatCnt;
   logic [1:0]       lastIdx;
   logic [ADR_W-1:0] texAdr;
   logic [5:0]       clutBlk;
   logic [8:0]       clutY;
   logic             texPend, clutPend, grant, texSet, clutSet, beatWr;
   src_t             grantSrc;

   // The served source is blocked from ISSUE through COOL so a held level is not re-captured.
   assign texSet  = i_tex_req  && !texPend  && !((state != IDLE) && (src == SRC_TEX));
   assign clutSet = i_clut_req && !clutPend && !((state != IDLE) && (src == SRC_CLUT));

   gpu_fill_rr2 uArb (
      .clk      (clk),
      .rst      (i_rst),
      .texSet   (texSet),
      .clutSet  (clutSet),
      .arbEn    (state == IDLE),
      .texPend  (texPend),
      .clutPend (clutPend),
      .grant    (grant),
      .grantSrc (grantSrc)
   );

   always_ff @(posedge clk) begin
      if (i_rst) begin
         texAdr  <= '0;
         clutBlk <= '0;
         clutY   <= '0;
      end else begin
         if (texSet)
            texAdr <= i_tex_adr;
         if (clutSet) begin
            clutBlk <= i_clut_blk;
            clutY   <= i_clut_y;
         end
      end
   end

   assign lastIdx = (src == SRC_TEX) ? 2'(TEX_BEATS - 1) : 2'(CLUT_BEATS - 1);
   assign beatWr  = (state == RECV) && i_mem_dvalid;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state       <= IDLE;
         src         <= SRC_TEX;
         beatCnt     <= '0;
         o_mem_req   <= 1'b0;
         o_mem_adr   <= '0;
         o_mem_len   <= '0;
         o_tex_done  <= 1'b0;
         o_clut_done <= 1'b0;
      end else begin
         o_tex_done  <= 1'b0;
         o_clut_done <= 1'b0;
         case (state)
            IDLE: if (grant) begin
               state     <= ISSUE;
               src       <= grantSrc;
               o_mem_req <= 1'b1;
               if (grantSrc == SRC_TEX) begin
                  o_mem_adr <= texAdr;
                  o_mem_len <= 3'(TEX_BEATS);
               end else begin
                  o_mem_adr <= {clutY, clutBlk, 2'b00};
                  o_mem_len <= 3'(CLUT_BEATS);
               end
            end
            ISSUE: if (i_mem_ack) begin
               state     <= RECV;
               o_mem_req <= 1'b0;
               beatCnt   <= '0;
            end
            RECV: if (i_mem_dvalid) begin
               beatCnt <= beatCnt + 2'd1;
               if (beatCnt == lastIdx) begin
                  state       <= DONE;
                  o_tex_done  <= (src == SRC_TEX);
                  o_clut_done <= (src == SRC_CLUT);
               end
            end
            DONE:    state <= COOL;
            COOL:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign o_tex_wr       = beatWr && (src == SRC_TEX);
   assign o_tex_wr_adr   = o_tex_wr ? texAdr : '0;
   assign o_tex_wr_data  = o_tex_wr ? i_mem_data : '0;
   assign o_clut_wr      = beatWr && (src == SRC_CLUT);
   assign o_clut_wr_beat = o_clut_wr ? beatCnt : '0;
   assign o_clut_wr_blk  = o_clut_wr ? clutBlk : '0;
   assign o_clut_wr_data = o_clut_wr ? i_mem_data : '0;

   assign o_busy  = (state != IDLE);
   assign o_pause = texPend || clutPend || (state != IDLE) || i_tex_req || i_clut_req;

   noBeatInIssue: assert property (@(posedge clk) disable iff (i_rst)
      !((state == ISSUE) && i_mem_dvalid));

endmodule
